// File: rtl/contador_u_sequencer.sv
// Units-digit sequencer: prescaled up/down counter 0..MAX with run/pause/done control.
// Optional macro CONTADOR_U_AUTORELOAD_EN: terminal step wraps and stays in RUN instead of DONE.
module contador_u_sequencer #(
    parameter int unsigned DIV = 50000000,
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       dir,
    output logic [3:0] count,
    output logic       tc,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0] COUNT_MAX = 4'(MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_q, dir_d;
    logic            tc_q, tc_d;
    logic            busy_q, done_q;

    logic            at_term;
    logic [3:0]      step_val;
    logic [3:0]      wrap_val;
    logic [3:0]      load_val;

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_PAUSE);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Step arithmetic for the latched direction; terminal value never steps past 0..MAX.
    always_comb begin
        at_term  = 1'b0;
        step_val = count_q;
        wrap_val = 4'd0;
        load_val = 4'd0;
        if (dir_q) begin
            at_term  = (count_q == 4'd0);
            step_val = count_q - 4'd1;
            wrap_val = COUNT_MAX;
        end else begin
            at_term  = (count_q == COUNT_MAX);
            step_val = count_q + 4'd1;
            wrap_val = 4'd0;
        end
        if (dir) begin
            load_val = COUNT_MAX;
        end
    end

    // Next-state logic; priority clear > start > pause.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            count_d = 4'd0;
            presc_d = '0;
        end else if (start) begin
            state_d = S_RUN;
            dir_d   = dir;
            count_d = load_val;
            presc_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (at_term) begin
                            tc_d = 1'b1;
`ifdef CONTADOR_U_AUTORELOAD_EN
                            count_d = wrap_val;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            count_d = step_val;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef CONTADOR_U_AUTORELOAD_EN
    // Wrap value only matters when autoreload is built in.
    logic unused_wrap;
    assign unused_wrap = ^wrap_val;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule
